udma_l2_mem_responder: RTL
==========================

# udma_l2_mem_responder

L2 memory-side endpoint for the uDMA core's two TCDM-style master ports: the read-only TX port and the write-only RX port. It arbitrates both ports onto one single-port word memory and issues grants and response-valid signals per the TCDM req/gnt/rvalid protocol. It is the slave end of the uDMA L2 interface and serves as the L2 model in subsystem benches and FPGA builds without the SoC interconnect. It includes optional pseudo-random grant stalling and an out-of-range access counter.

## Interface
- DATA_WIDTH, 32, word width; byte-enable width is DATA_WIDTH/8
- MEM_WORDS, 4096, memory depth in words (power of two)
- BASE_ADDR, 32'h1C00_0000, byte address of word 0
- LFSR_SEED, 16'hACE1, stall LFSR reset value (non-zero)
- sys_clk_i  in  1  sole clock
- sys_rst_i  in  1  reset; synchronous, active-high
- ro_req_i / wo_req_i  in  1  request, per port
- ro_gnt_o / wo_gnt_o  out  1  grant, per port
- ro_addr_i / wo_addr_i  in  32  byte address
- ro_wen_i / wo_wen_i  in  1  1 = read, 0 = write
- ro_be_i / wo_be_i  in  DATA_WIDTH/8  write byte enables
- ro_wdata_i / wo_wdata_i  in  DATA_WIDTH  write data
- ro_rvalid_o / wo_rvalid_o  out  1  response valid
- ro_rdata_o / wo_rdata_o  out  DATA_WIDTH  read data
- stall_en_i  in  1  enables pseudo-random grant suppression
- err_count_o  out  16  saturating count of out-of-range accesses

## Operation
- Each port uses the same rules: wen=1 is a read and wen=0 is a write. Port ro is not forced to read-only.
- Word index is (addr − BASE_ADDR) >> 2; addr[1:0] is ignored.
- An access is in range when BASE_ADDR ≤ addr < BASE_ADDR + 4·MEM_WORDS; otherwise it is out of range.
- At most one access is granted per cycle.
- A port is eligible when its req is 1 and the stall is inactive.
- If exactly one port is eligible, it is granted.
- If both ports are eligible, the port holding priority is granted. After every contended grant, priority moves to the loser.
- Priority is held in a 1-bit register; its reset value selects wo.
- Uncontended grants do not change priority.
- Stall LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11; resets to LFSR_SEED.
  - Shifts every cycle regardless of stall_en_i.
  - When stall_en_i=1 and lfsr[0]=1, both grants are 0 that cycle.
- Granted write, in range: bytes with be[i]=1 are written at the clock edge of the grant cycle; other bytes are unchanged.
- Granted read, in range: returns the memory word, including a write committed on any earlier edge.
- Out-of-range access:
  - Still granted and responded to.
  - A write is dropped.
  - A read returns 32'hBADA_CCE5.
  - err_count_o increments by 1 and saturates at 16'hFFFF.
- Every granted access, read or write, produces exactly one rvalid on its own port.
- rdata is 0 for write responses.
- The master holds req, addr, wen, be and wdata stable until granted. The responder does not check this.

## Timing
- gnt is combinational from req, the priority register, the LFSR and stall_en_i.
- Grant is zero-wait when no stall or contention applies.
- rvalid and rdata are registered and appear exactly 1 cycle after the grant cycle. Latency is fixed.
- Back-to-back grants on the same port give back-to-back rvalids.
- A port can receive rvalid for one access in the same cycle it receives gnt for the next.
- Write then read of the same word:
  - Write granted at cycle N, read granted at N+1 → read returns the new data at N+2.
  - Same-cycle contention between them resolves by priority; the read returns pre- or post-write data accordingly.
- While sys_rst_i=1:
  - ro_gnt_o and wo_gnt_o = 0.
  - ro_rvalid_o and wo_rvalid_o = 0.
  - ro_rdata_o and wo_rdata_o = 0.
  - err_count_o = 0.
  - LFSR = LFSR_SEED; priority = wo.
- Reset mid-operation: any response due the cycle after reset asserts is cancelled (rvalid=0), and no write commits on a reset edge.
- Memory contents are not reset.

## Test plan
- Write wo addr 0x1C00_0010, data 0xDEAD_BEEF, be 4'hF, then read on ro → wo_gnt same cycle as req; wo_rvalid at +1; ro_rdata = 0xDEAD_BEEF one cycle after ro grant.
- Partial write: initial word 0x1111_1111, write 0xAABB_CCDD with be 4'b0101 → read returns 0x11BB_11DD.
- Both ports request continuously for 6 cycles after reset → grants alternate wo, ro, wo, ro, wo, ro; each rvalid lags its grant by 1.
- Read at 0x1C00_4000 and write at 0x0000_0000 with MEM_WORDS=4096 → read returns 0xBADA_CCE5, memory unchanged, err_count_o = 2.
- stall_en_i=1, single port requesting → grant suppressed exactly on cycles where the reference LFSR model has lfsr[0]=1; all 100 accesses complete in order with correct data.
- Assert sys_rst_i in the cycle after a read grant → no rvalid; outputs at reset values; a read after reset returns data written before reset.

Source files
------------

// File: rtl/udma_l2_mem_responder.sv
// -----------------------------------------------------------------------------
// udma_l2_mem_responder
//
// L2 memory-side endpoint for the uDMA TX (ro) and RX (wo) TCDM master ports.
// Both ports are arbitrated onto one single-port word memory. Each granted
// access gets a single rvalid on its own port one cycle after its grant.
//
// Ports
//   sys_clk_i, sys_rst_i     clock, synchronous active-high reset
//   ro_* / wo_*              TCDM req/gnt/addr/wen/be/wdata/rvalid/rdata,
//                            wen = 1 means read, wen = 0 means write
//   stall_en_i               enables pseudo-random grant suppression
//   err_count_o              saturating count of out-of-range accesses
// -----------------------------------------------------------------------------
module udma_l2_mem_responder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_WORDS  = 4096,
   parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                    sys_clk_i,
   input  logic                    sys_rst_i,
   input  logic                    ro_req_i,
   output logic                    ro_gnt_o,
   input  logic [31:0]             ro_addr_i,
   input  logic                    ro_wen_i,
   input  logic [DATA_WIDTH/8-1:0] ro_be_i,
   input  logic [DATA_WIDTH-1:0]   ro_wdata_i,
   output logic                    ro_rvalid_o,
   output logic [DATA_WIDTH-1:0]   ro_rdata_o,
   input  logic                    wo_req_i,
   output logic                    wo_gnt_o,
   input  logic [31:0]             wo_addr_i,
   input  logic                    wo_wen_i,
   input  logic [DATA_WIDTH/8-1:0] wo_be_i,
   input  logic [DATA_WIDTH-1:0]   wo_wdata_i,
   output logic                    wo_rvalid_o,
   output logic [DATA_WIDTH-1:0]   wo_rdata_o,
   input  logic                    stall_en_i,
   output logic [15:0]             err_count_o
);

   localparam int unsigned           BE_W      = DATA_WIDTH / 8;
   localparam int unsigned           IDX_W     = $clog2(MEM_WORDS);
   localparam logic [31:0]           MEM_BYTES = 32'(MEM_WORDS * 4);
   localparam logic [DATA_WIDTH-1:0] OOR_RDATA = DATA_WIDTH'(32'hBADA_CCE5);
   localparam logic                  PRIO_WO   = 1'b0;
   localparam logic                  PRIO_RO   = 1'b1;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      logic fb;
      fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
      return {fb, cur[15:1]};
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];

   logic [15:0]           lfsr_r;
   logic                  prio_r;
   logic [15:0]           err_cnt_r;
   logic                  ro_rvalid_r;
   logic                  wo_rvalid_r;
   logic [DATA_WIDTH-1:0] ro_rdata_r;
   logic [DATA_WIDTH-1:0] wo_rdata_r;

   logic                  stall_s;
   logic                  ro_elig_s;
   logic                  wo_elig_s;
   logic                  ro_gnt_s;
   logic                  wo_gnt_s;
   logic                  prio_nxt_s;
   logic                  gnt_any_s;
   logic [31:0]           acc_addr_s;
   logic                  acc_wen_s;
   logic [BE_W-1:0]       acc_be_s;
   logic [DATA_WIDTH-1:0] acc_wdata_s;
   logic [31:0]           acc_off_s;
   logic                  acc_inr_s;
   logic [IDX_W-1:0]      acc_idx_s;
   logic [DATA_WIDTH-1:0] rd_word_s;
   logic [DATA_WIDTH-1:0] resp_data_s;

   // Grant arbitration: stall gate, then fixed one-hot grant with rotating
   // priority that only moves to the loser on a contended cycle.
   always_comb begin
      stall_s    = stall_en_i & lfsr_r[0];
      ro_elig_s  = ro_req_i & ~stall_s & ~sys_rst_i;
      wo_elig_s  = wo_req_i & ~stall_s & ~sys_rst_i;
      ro_gnt_s   = 1'b0;
      wo_gnt_s   = 1'b0;
      prio_nxt_s = prio_r;
      if (ro_elig_s && wo_elig_s) begin
         if (prio_r == PRIO_RO) begin
            ro_gnt_s   = 1'b1;
            prio_nxt_s = PRIO_WO;
         end else begin
            wo_gnt_s   = 1'b1;
            prio_nxt_s = PRIO_RO;
         end
      end else begin
         ro_gnt_s = ro_elig_s;
         wo_gnt_s = wo_elig_s;
      end
   end

   // Select the winning port's access and decode its address.
   always_comb begin
      if (ro_gnt_s) begin
         acc_addr_s  = ro_addr_i;
         acc_wen_s   = ro_wen_i;
         acc_be_s    = ro_be_i;
         acc_wdata_s = ro_wdata_i;
      end else begin
         acc_addr_s  = wo_addr_i;
         acc_wen_s   = wo_wen_i;
         acc_be_s    = wo_be_i;
         acc_wdata_s = wo_wdata_i;
      end
      gnt_any_s = ro_gnt_s | wo_gnt_s;
      // Offset wraps to a huge value below BASE_ADDR, the first term
      // keeps the check correct even if BASE_ADDR + MEM_BYTES overflows.
      acc_off_s = acc_addr_s - BASE_ADDR;
      acc_inr_s = (acc_addr_s >= BASE_ADDR) && (acc_off_s < MEM_BYTES);
      acc_idx_s = acc_off_s[IDX_W+1:2];
      rd_word_s = mem_r[acc_idx_s];
      if (!acc_wen_s) begin
         resp_data_s = {DATA_WIDTH{1'b0}};
      end else if (acc_inr_s) begin
         resp_data_s = rd_word_s;
      end else begin
         resp_data_s = OOR_RDATA;
      end
   end

   // Memory write port; contents are intentionally not reset. Grants are
   // forced low during reset, so no write commits on a reset edge.
   always_ff @(posedge sys_clk_i) begin
      if (gnt_any_s && acc_inr_s && !acc_wen_s) begin
         for (int b = 0; b < BE_W; b++) begin
            if (acc_be_s[b]) begin
               mem_r[acc_idx_s][b*8 +: 8] <= acc_wdata_s[b*8 +: 8];
            end
         end
      end
   end

   // Control state and registered responses.
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         lfsr_r      <= LFSR_SEED;
         prio_r      <= PRIO_WO;
         err_cnt_r   <= 16'h0000;
         ro_rvalid_r <= 1'b0;
         wo_rvalid_r <= 1'b0;
         ro_rdata_r  <= {DATA_WIDTH{1'b0}};
         wo_rdata_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         lfsr_r      <= lfsr_next(lfsr_r);
         prio_r      <= prio_nxt_s;
         ro_rvalid_r <= ro_gnt_s;
         wo_rvalid_r <= wo_gnt_s;
         ro_rdata_r  <= ro_gnt_s ? resp_data_s : {DATA_WIDTH{1'b0}};
         wo_rdata_r  <= wo_gnt_s ? resp_data_s : {DATA_WIDTH{1'b0}};
         if (gnt_any_s && !acc_inr_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
         end else begin
            err_cnt_r <= err_cnt_r;
         end
      end
   end

   // Outputs are forced to their reset values for the whole time reset is
   // high, which also cancels a response due in the first reset cycle.
   assign ro_gnt_o    = ro_gnt_s;
   assign wo_gnt_o    = wo_gnt_s;
   assign ro_rvalid_o = ro_rvalid_r & ~sys_rst_i;
   assign wo_rvalid_o = wo_rvalid_r & ~sys_rst_i;
   assign ro_rdata_o  = sys_rst_i ? {DATA_WIDTH{1'b0}} : ro_rdata_r;
   assign wo_rdata_o  = sys_rst_i ? {DATA_WIDTH{1'b0}} : wo_rdata_r;
   assign err_count_o = sys_rst_i ? 16'h0000 : err_cnt_r;

endmodule
